// File: rtl/rc4_pkg.sv
// +-----------------------------------------------------------------------+
// | rc4_pkg : shared RC4 constants and the key-schedule state encoding    |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
`default_nettype none

package rc4_pkg;

  localparam int KEY_BYTES   = 3;
  localparam int S_SIZE      = 256;
  localparam int ITER_CYCLES = 8;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_I   = 4'd1,
    WAIT_I = 4'd2,
    CAP_I  = 4'd3,
    RD_J   = 4'd4,
    WAIT_J = 4'd5,
    CAP_J  = 4'd6,
    WR_I   = 4'd7,
    WR_J   = 4'd8
  } ksa_state_t;

  // Wrapping counter over the key bytes; replaces i mod KEY_BYTES.
  function automatic logic [7:0] next_kidx(input logic [7:0] k);
    return (k == 8'(KEY_BYTES - 1)) ? 8'd0 : k + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ksa_if.sv
// +-----------------------------------------------------------------------+
// | ksa_if : start handshake, key and S-memory port of the KSA block      |
// | Optional done pulse under KSA_DONE_PULSE_EN.  Rev 1.0                 |
// +-----------------------------------------------------------------------+
`default_nettype none

interface ksa_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  s_addr;
  logic [7:0]  s_rddata;
  logic [7:0]  s_wrdata;
  logic        s_wren;
`ifdef KSA_DONE_PULSE_EN
  logic        done;
`endif

  modport master (
    output en, key, s_rddata,
`ifdef KSA_DONE_PULSE_EN
    input  done,
`endif
    input  rdy, s_addr, s_wrdata, s_wren
  );

  modport slave (
    input  en, key, s_rddata,
`ifdef KSA_DONE_PULSE_EN
    output done,
`endif
    output rdy, s_addr, s_wrdata, s_wren
  );
endinterface

`default_nettype wire

// File: rtl/ksa.sv
// +-----------------------------------------------------------------------+
// | ksa : RC4 key schedule over an external synchronous S-memory          |
// | Optional one-cycle done pulse under KSA_DONE_PULSE_EN.  Rev 1.0       |
// +-----------------------------------------------------------------------+
`default_nettype none

module ksa
  import rc4_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst_n,
  ksa_if.slave      bus
);

  ksa_state_t  state;
  ksa_state_t  state_nx;

  logic [7:0]  r_i;
  logic [7:0]  r_j;
  logic [7:0]  r_si;
  logic [7:0]  r_sj;
  logic [7:0]  r_kidx;
  logic [23:0] r_key;
  logic [7:0]  w_keybyte;
  logic        w_last;

  assign w_last = (r_i == 8'(S_SIZE - 1));

  always_comb begin
    case (r_kidx)
      8'd0:    w_keybyte = r_key[23:16];
      8'd1:    w_keybyte = r_key[15:8];
      default: w_keybyte = r_key[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.rdy      = 1'b0;
    bus.s_wren   = 1'b0;
    bus.s_addr   = 8'd0;
    bus.s_wrdata = 8'd0;
    case (state)
      IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) state_nx = RD_I;
      end
      // Address is held through the wait so the RAM output stays stable for capture.
      RD_I: begin
        bus.s_addr = r_i;
        state_nx   = WAIT_I;
      end
      WAIT_I: begin
        bus.s_addr = r_i;
        state_nx   = CAP_I;
      end
      CAP_I: begin
        bus.s_addr = r_i;
        state_nx   = RD_J;
      end
      RD_J: begin
        bus.s_addr = r_j;
        state_nx   = WAIT_J;
      end
      WAIT_J: begin
        bus.s_addr = r_j;
        state_nx   = CAP_J;
      end
      CAP_J: begin
        bus.s_addr = r_j;
        state_nx   = WR_I;
      end
      WR_I: begin
        bus.s_wren   = 1'b1;
        bus.s_addr   = r_i;
        bus.s_wrdata = r_sj;
        state_nx     = WR_J;
      end
      WR_J: begin
        bus.s_wren   = 1'b1;
        bus.s_addr   = r_j;
        bus.s_wrdata = r_si;
        state_nx     = w_last ? IDLE : RD_I;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i    <= 8'd0;
      r_j    <= 8'd0;
      r_si   <= 8'd0;
      r_sj   <= 8'd0;
      r_kidx <= 8'd0;
      r_key  <= 24'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            r_i    <= 8'd0;
            r_j    <= 8'd0;
            r_kidx <= 8'd0;
            r_key  <= bus.key;
          end
        end
        CAP_I: begin
          r_si <= bus.s_rddata;
          r_j  <= r_j + bus.s_rddata + w_keybyte;
        end
        CAP_J: r_sj <= bus.s_rddata;
        WR_J: begin
          if (!w_last) begin
            r_i    <= r_i + 8'd1;
            r_kidx <= next_kidx(r_kidx);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KSA_DONE_PULSE_EN
  logic r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= (state == WR_J) && w_last;
  end

  assign bus.done = r_done;
`endif

endmodule

`default_nettype wire
